// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch path: NOP encoding, branch counter
// states, BTB entry layout and the saturating counter step.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // tag holds the word address shifted right by the index width,
    // zero-extended to 30 bits so one layout serves any table size.
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [31:0] target;
        logic [1:0]  ctr;
    } btb_entry_t;

    function automatic logic [1:0] ctr_step(logic [1:0] c, logic taken);
        logic [1:0] n;
        n = c;
        if (taken && c != CTR_ST)
            n = c + 2'd1;
        else if (!taken && c != CTR_SNT)
            n = c - 2'd1;
        return n;
    endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit counters. Ports: clk, rst (async, high);
// lookup lk_wpc -> lk_hit/lk_ctr_hi/lk_target (comb); upd_* (sync).
module branch_target_buffer
    import riscv_pkg::*;
#(
    parameter int ENTRIES = 16,
    localparam int IDX_W = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] lk_wpc,
    output logic        lk_hit,
    output logic        lk_ctr_hi,
    output logic [31:0] lk_target,
    input  logic        upd_valid,
    input  logic [29:0] upd_wpc,
    input  logic        upd_taken,
    input  logic [29:0] upd_wtgt
);

    btb_entry_t tbl_q [ENTRIES];
    btb_entry_t tbl_d [ENTRIES];

    logic [IDX_W-1:0] l_idx;
    logic [29:0]      l_tag;
    btb_entry_t       l_ent;

    assign l_idx = lk_wpc[IDX_W-1:0];
    assign l_tag = lk_wpc >> IDX_W;
    assign l_ent = tbl_q[l_idx];

    assign lk_hit    = l_ent.valid && (l_ent.tag == l_tag);
    assign lk_ctr_hi = l_ent.ctr[1];
    assign lk_target = l_ent.target;

    logic [IDX_W-1:0] u_idx;
    logic [29:0]      u_tag;
    btb_entry_t       u_ent;
    logic             u_hit;

    assign u_idx = upd_wpc[IDX_W-1:0];
    assign u_tag = upd_wpc >> IDX_W;
    assign u_ent = tbl_q[u_idx];
    assign u_hit = u_ent.valid && (u_ent.tag == u_tag);

    always_comb begin
        tbl_d = tbl_q;
        if (upd_valid) begin
            if (u_hit) begin
                tbl_d[u_idx].ctr = ctr_step(u_ent.ctr, upd_taken);
                if (upd_taken)
                    tbl_d[u_idx].target = {upd_wtgt, 2'b00};
            end else if (upd_taken) begin
                // Allocation evicts whatever aliased into this slot.
                tbl_d[u_idx].valid  = 1'b1;
                tbl_d[u_idx].tag    = u_tag;
                tbl_d[u_idx].target = {upd_wtgt, 2'b00};
                tbl_d[u_idx].ctr    = CTR_WT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_q[i].valid  <= 1'b0;
                tbl_q[i].tag    <= '0;
                tbl_q[i].target <= '0;
                tbl_q[i].ctr    <= CTR_WNT;
            end
        end else begin
            tbl_q <= tbl_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC register, next-PC selection, BTB prediction, bubble on
// imem miss. Ports: clk/rst, stall, redirect_*, update_*, imem_*, if_*.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        update_valid,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic [31:0] update_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instruction,
    output logic        if_predict_taken,
    output logic [31:0] if_predict_target,
    output logic        fetch_miss
);

    localparam logic [31:0] RST_PC = {RESET_PC[31:2], 2'b00};

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    logic        btb_hit;
    logic        btb_ctr_hi;
    logic [31:0] btb_target;
    logic        pred_taken;

    branch_target_buffer #(
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk       (clk),
        .rst       (rst),
        .lk_wpc    (pc_q[31:2]),
        .lk_hit    (btb_hit),
        .lk_ctr_hi (btb_ctr_hi),
        .lk_target (btb_target),
        .upd_valid (update_valid),
        .upd_wpc   (update_pc[31:2]),
        .upd_taken (update_taken),
        .upd_wtgt  (update_target[31:2])
    );

    // Low address bits are ignored everywhere: PCs are word aligned.
    logic unused_lsbs;
    assign unused_lsbs = ^{redirect_pc[1:0], update_pc[1:0],
                           update_target[1:0]};

    assign pred_taken = btb_hit && btb_ctr_hi && imem_ready;

    assign imem_addr         = pc_q;
    assign if_pc             = pc_q;
    assign if_instruction    = imem_ready ? imem_rdata : NOP_INSTR;
    assign if_predict_taken  = pred_taken;
    assign if_predict_target = pred_taken ? btb_target : 32'h0;
    assign fetch_miss        = !imem_ready;

    always_comb begin
        pc_d = pc_q + 32'd4;
        if (redirect_valid)
            pc_d = {redirect_pc[31:2], 2'b00};
        else if (stall || !imem_ready)
            pc_d = pc_q;
        else if (pred_taken)
            pc_d = btb_target;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pc_q <= RST_PC;
        else
            pc_q <= pc_d;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized + directed bench for fetch_unit against a table-based
// reference model of PC sequencing and BTB training.
module tb_fetch_unit;

    localparam int NENT = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic        if_predict_taken;
    logic [31:0] if_predict_target;
    logic        fetch_miss;

    fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .BTB_ENTRIES (NENT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .update_valid      (update_valid),
        .update_pc         (update_pc),
        .update_taken      (update_taken),
        .update_target     (update_target),
        .imem_addr         (imem_addr),
        .imem_rdata        (imem_rdata),
        .imem_ready        (imem_ready),
        .if_pc             (if_pc),
        .if_instruction    (if_instruction),
        .if_predict_taken  (if_predict_taken),
        .if_predict_target (if_predict_target),
        .fetch_miss        (fetch_miss)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: one record per BTB slot, counter as an integer.
    bit [31:0] m_pc;
    bit        m_valid [NENT];
    bit [31:0] m_tag   [NENT];
    bit [31:0] m_tgt   [NENT];
    int        m_ctr   [NENT];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int slot(bit [31:0] a);
        return int'((a / 4) % NENT);
    endfunction

    function automatic bit m_hit(bit [31:0] a);
        return m_valid[slot(a)] && m_tag[slot(a)] == a / (4 * NENT);
    endfunction

    function automatic bit m_pred();
        return imem_ready && m_hit(m_pc) && m_ctr[slot(m_pc)] >= 2;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0;
        for (int i = 0; i < NENT; i++) begin
            m_valid[i] = 0;
            m_tag[i]   = 0;
            m_tgt[i]   = 0;
            m_ctr[i]   = 1;
        end
    endtask

    task automatic check_outputs();
        bit p;
        p = m_pred();
        chk("imem_addr", imem_addr, m_pc);
        chk("if_pc", if_pc, m_pc);
        chk("if_instr", if_instruction, imem_ready ? imem_rdata : NOP);
        chk("pred_taken", {31'b0, if_predict_taken}, {31'b0, p});
        chk("pred_target", if_predict_target, p ? m_tgt[slot(m_pc)] : 0);
        chk("fetch_miss", {31'b0, fetch_miss}, {31'b0, !imem_ready});
    endtask

    task automatic model_step();
        bit [31:0] npc;
        int s;
        if (redirect_valid)
            npc = redirect_pc & ~32'd3;
        else if (stall || !imem_ready)
            npc = m_pc;
        else if (m_pred())
            npc = m_tgt[slot(m_pc)];
        else
            npc = m_pc + 32'd4;
        if (update_valid) begin
            s = slot(update_pc);
            if (m_hit(update_pc)) begin
                if (update_taken) begin
                    m_ctr[s] = m_ctr[s] == 3 ? 3 : m_ctr[s] + 1;
                    m_tgt[s] = update_target & ~32'd3;
                end else begin
                    m_ctr[s] = m_ctr[s] == 0 ? 0 : m_ctr[s] - 1;
                end
            end else if (update_taken) begin
                m_valid[s] = 1;
                m_tag[s]   = update_pc / (4 * NENT);
                m_tgt[s]   = update_target & ~32'd3;
                m_ctr[s]   = 2;
            end
        end
        m_pc = npc;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic idle();
        stall          = 0;
        redirect_valid = 0;
        redirect_pc    = 0;
        update_valid   = 0;
        update_pc      = 0;
        update_taken   = 0;
        update_target  = 0;
        imem_ready     = 1;
        imem_rdata     = $urandom;
    endtask

    task automatic train(bit [31:0] pc, bit tk, bit [31:0] tg);
        idle();
        update_valid  = 1;
        update_pc     = pc;
        update_taken  = tk;
        update_target = tg;
        cycle();
        idle();
    endtask

    task automatic probe(bit [31:0] a, bit exp_pt);
        idle();
        redirect_valid = 1;
        redirect_pc    = a;
        cycle();
        idle();
        chk("probe_pc", if_pc, a);
        chk("probe_pt", {31'b0, if_predict_taken}, {31'b0, exp_pt});
    endtask

    initial begin
        idle();
        rst        = 1;
        imem_rdata = 32'h1234_5678;
        #2;
        model_reset();
        check_outputs();
        imem_ready = 0;
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        rst = 0;
        idle();

        // Sequential fetch from reset.
        for (int i = 0; i < 2; i++) begin
            chk("seq_pc", if_pc, 32'(i * 4));
            cycle();
        end
        chk("seq_pc", if_pc, 32'd8);

        // Stall holds PC at 8.
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_pc", if_pc, 32'd8);
        end
        idle();

        // imem miss bubbles and holds.
        imem_ready = 0;
        #1;
        chk("miss_instr", if_instruction, NOP);
        chk("miss_flag", {31'b0, fetch_miss}, 32'd1);
        cycle();
        chk("miss_pc", if_pc, 32'd8);
        idle();
        cycle();
        chk("seq_pc", if_pc, 32'd12);

        // Redirect beats stall, low bits dropped.
        stall          = 1;
        redirect_valid = 1;
        redirect_pc    = 32'h103;
        cycle();
        idle();
        chk("redir_pc", if_pc, 32'h100);

        // Allocate and predict.
        train(32'h40, 1, 32'h80);
        probe(32'h40, 1);
        chk("pred_tgt", if_predict_target, 32'h80);
        cycle();
        chk("pred_next", if_pc, 32'h80);

        // Counter saturation.
        train(32'h40, 0, 0);
        train(32'h40, 0, 0);
        probe(32'h40, 0);
        train(32'h40, 0, 0);
        train(32'h40, 1, 32'h80);
        probe(32'h40, 0);
        train(32'h40, 1, 32'h80);
        probe(32'h40, 1);

        // Aliasing, not-taken miss, wrap.
        train(32'h80, 1, 32'hC0);
        probe(32'h40, 0);
        probe(32'h80, 1);
        train(32'h44, 0, 32'h200);
        probe(32'h44, 0);
        probe(32'hFFFF_FFFC, 0);
        cycle();
        chk("wrap_pc", if_pc, 32'h0);

        // Randomized traffic over a small address window.
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                rst = 1;
                #1;
                model_reset();
                check_outputs();
                @(posedge clk);
                #1;
                rst = 0;
            end
            stall          = ($urandom % 10) == 0;
            imem_ready     = ($urandom % 8) != 0;
            imem_rdata     = $urandom;
            redirect_valid = ($urandom % 12) == 0;
            redirect_pc    = ($urandom % 50 == 0) ? 32'hFFFF_FFF0 + ($urandom % 16)
                                                  : $urandom_range(0, 511);
            update_valid   = ($urandom % 3) == 0;
            update_pc      = $urandom_range(0, 511);
            update_taken   = $urandom % 2;
            update_target  = $urandom_range(0, 511);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage: owns the PC register, drives the instruction-memory address, and produces `if_pc`, `if_instruction`, `if_predict_taken` and `if_predict_target` for the IF/ID pipeline register.
- Contains a direct-mapped BTB with 2-bit saturating counters for branch prediction.
- Trained by branch resolution from the MEM stage; redirected on misprediction.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BTB_ENTRIES, 16, number of BTB entries (power of 2, ≥2); IDX_W = log2(BTB_ENTRIES).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold PC (hazard/cache-miss stall from hazard unit)
- redirect_valid  in  1  misprediction correction from MEM stage
- redirect_pc  in  32  correct next PC
- update_valid  in  1  resolved branch/jump in MEM stage
- update_pc  in  32  PC of resolved instruction
- update_taken  in  1  actual outcome
- update_target  in  32  actual taken target
- imem_addr  out  32  instruction address (= PC)
- imem_rdata  in  32  instruction word
- imem_ready  in  1  imem_rdata valid this cycle
- if_pc  out  32  PC of emitted instruction
- if_instruction  out  32  instruction or NOP bubble
- if_predict_taken  out  1  BTB predicts taken
- if_predict_target  out  32  predicted target (0 when not taken)
- fetch_miss  out  1  imem not ready; bubble emitted

Behaviour:
- **Clock and reset.** Reset: rst, asynchronous, active-high; clock clk.
  - PC ← {RESET_PC[31:2],2'b00}.
  - All BTB valid bits ← 0; counters ← 2'b01.
- **Outputs during reset.** imem_addr = if_pc = RESET_PC; if_instruction = NOP (32'h00000013) unless imem_ready; if_predict_taken = 0; if_predict_target = 0; fetch_miss = !imem_ready.
- **Combinational outputs.** All outputs are combinational from the PC register, the BTB arrays, imem_rdata and imem_ready. There is zero-cycle latency from PC to outputs.
- **BTB lookup.**
  - idx = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2].
  - hit = valid[idx] && tag match.
  - predict_taken = hit && ctr[idx][1] && imem_ready.
  - if_predict_target = predict_taken ? tgt[idx] : 0.
- **Bubble.** When imem_ready = 0:
  - if_instruction = NOP, predict_taken = 0, fetch_miss = 1.
  - if_pc = pc.
- **Next-PC priority, evaluated at posedge.**
  1. redirect_valid → redirect_pc with [1:0] forced to 00. Redirect overrides stall and miss.
  2. stall or !imem_ready → hold PC.
  3. predict_taken → tgt[idx].
  4. Otherwise pc+4, modulo 2^32 (32'hFFFF_FFFC → 0).
- **BTB update, at posedge when update_valid.** u_idx/u_tag are taken from update_pc.
  - Entry hit: ctr saturating increment if taken (11 stays 11), decrement if not (00 stays 00); if taken, tgt ← update_target.
  - Entry miss and taken: allocate valid ← 1, tag ← u_tag, tgt ← update_target, ctr ← 2'b10. This replaces any previous occupant.
  - Entry miss and not taken: no change.
  - update_target[1:0] is stored as 00.
- **Simultaneous events.**
  - Update and lookup at the same idx in the same cycle: the lookup uses the pre-update contents; the new contents are visible next cycle.
  - Update is independent of stall and redirect; it is always applied.
- **Qualification.** The MEM stage qualifies redirect_valid/update_valid with its own stall. The fetch unit does not filter them.
- **Reset mid-operation.** Immediate and asynchronous; BTB training is lost.

Decomposition:
- Shared package riscv_pkg:
  - NOP_INSTR = 32'h00000013.
  - Counter constants: CTR_SNT = 00, CTR_WNT = 01, CTR_WT = 10, CTR_ST = 11.
  - typedef btb_entry_t {valid, tag, target, ctr}.
- One sub-module: branch_target_buffer.
  - Lookup port: combinational.
  - Update port: synchronous.
  - Owns the arrays and reset clearing.
- fetch_unit keeps the PC register and next-PC mux.

Test Plan:
- **Reset, sequential fetch.** RESET_PC = 0, imem_ready = 1, no stall → if_pc = 0, 4, 8, 12 on consecutive cycles; if_predict_taken = 0.
- **Stall and miss.**
  - stall = 1 for 3 cycles at pc = 8 → if_pc holds 8.
  - imem_ready = 0 → if_instruction = 0x00000013, fetch_miss = 1, PC holds.
- **Redirect priority.** stall = 1 with redirect_valid = 1, redirect_pc = 0x103 → next if_pc = 0x100.
- **Allocate and predict.** update pc = 0x40, taken, target 0x80 → on the next fetch of 0x40: if_predict_taken = 1, if_predict_target = 0x80, following if_pc = 0x80.
- **Counter saturation.**
  - Two not-taken updates on 0x40 (10 → 01 → 00) → predict not-taken; a third stays 00.
  - Then one taken update (01) still predicts not-taken; a second (10) predicts taken.
- **Aliasing, not-taken allocate, wrap.**
  - Allocate 0x40 taken, then update 0x80 taken (same idx with 16 entries, different tag) → 0x40 is no longer a hit.
  - A not-taken update to a missing entry leaves valid = 0.
  - Redirect to 0xFFFFFFFC → next if_pc = 0.
